// File: rtl/servo_slew_pkg.sv
// Shared types and helpers for the servo slew limiter (servo_slew_ctrl, servo_slew_channel).
package servo_slew_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE   = 2'd1,
        ST_SETTLE = 2'd2
    } slew_state_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Dwell counter must hold SETTLE_TICKS-1; keep at least one bit for the degenerate case.
    function automatic int dwell_width(input int settle_ticks);
        return (settle_ticks > 1) ? $clog2(settle_ticks) : 1;
    endfunction

    function automatic int unsigned clamp_angle(input int unsigned a,
                                                input int unsigned lo,
                                                input int unsigned hi);
        if (a < lo) return lo;
        if (a > hi) return hi;
        return a;
    endfunction

endpackage

// File: rtl/servo_slew_channel.sv
// One servo channel: clamp target, step angle toward it on rate ticks, dwell, then report done.
// SERVO_SLEW_ACCEL_EN adds a per-tick step ramp from STEP up to MAX_STEP.
module servo_slew_channel
    import servo_slew_pkg::*;
#(
    parameter int ANGLE_W      = 8,
    parameter int MIN_ANGLE    = 0,
    parameter int MAX_ANGLE    = 180,
    parameter int RESET_ANGLE  = 90,
    parameter int STEP         = 1,
`ifdef SERVO_SLEW_ACCEL_EN
    parameter int MAX_STEP     = 4,
`endif
    parameter int SETTLE_TICKS = 8
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iTick,
    input  logic               iEn,
    input  logic [ANGLE_W-1:0] iTarget,
    output logic [ANGLE_W-1:0] oAngle,
    output logic               oMoving,
    output logic               oDone
);

    localparam int              DW         = dwell_width(SETTLE_TICKS);
    localparam logic [DW-1:0]   DWELL_LAST = DW'(SETTLE_TICKS - 1);
    localparam logic [DW-1:0]   DWELL_ONE  = DW'(1);
    localparam logic [ANGLE_W:0] STEP_W    = (ANGLE_W+1)'(STEP);

    slew_state_e        r_state;
    logic [ANGLE_W-1:0] r_angle;
    logic [DW-1:0]      r_dwell;
    logic               r_moving;
    logic               r_done;

    logic [ANGLE_W-1:0] w_tgt;
    logic [ANGLE_W:0]   w_diff;
    logic [ANGLE_W:0]   w_mag;
    logic [ANGLE_W:0]   w_step;
    logic [ANGLE_W:0]   w_delta;
    logic               w_dir;
    logic               w_land;
    logic [ANGLE_W-1:0] w_next_angle;

    assign w_tgt  = ANGLE_W'(clamp_angle(32'(iTarget), MIN_ANGLE, MAX_ANGLE));

    // One extra bit so the sign of tgt-ang survives at both ends of the angle range.
    assign w_diff = {1'b0, w_tgt} - {1'b0, r_angle};
    assign w_dir  = w_diff[ANGLE_W] ? DIR_DN : DIR_UP;
    assign w_mag  = w_diff[ANGLE_W] ? ({1'b0, r_angle} - {1'b0, w_tgt}) : w_diff;

`ifdef SERVO_SLEW_ACCEL_EN
    localparam logic [ANGLE_W:0] MAX_STEP_W = (ANGLE_W+1)'(MAX_STEP);
    localparam logic [ANGLE_W:0] STEP_ONE   = (ANGLE_W+1)'(1);

    logic [ANGLE_W:0] r_step;
    logic             r_dir;

    // A reversal restarts the ramp on the very step that changes direction.
    assign w_step = (w_dir != r_dir) ? STEP_W : r_step;
`else
    assign w_step = STEP_W;
`endif

    assign w_delta      = (w_mag < w_step) ? w_mag : w_step;
    assign w_land       = (w_delta == w_mag);
    assign w_next_angle = (w_dir == DIR_UP) ? (r_angle + w_delta[ANGLE_W-1:0])
                                            : (r_angle - w_delta[ANGLE_W-1:0]);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state  <= ST_IDLE;
            r_angle  <= ANGLE_W'(RESET_ANGLE);
            r_dwell  <= '0;
            r_moving <= 1'b0;
            r_done   <= 1'b0;
`ifdef SERVO_SLEW_ACCEL_EN
            r_step   <= STEP_W;
            r_dir    <= DIR_UP;
`endif
        end else begin
            // NOTE: these defaults are overridden by any later non-blocking assignment in this
            // block, so the flags always describe the state being entered, never a stale one.
            r_moving <= (r_state == ST_MOVE);
            r_done   <= (r_state == ST_IDLE);
            if (iEn) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_tgt != r_angle) begin
                            r_state  <= ST_MOVE;
                            r_moving <= 1'b1;
                            r_done   <= 1'b0;
                        end
                    end
                    ST_MOVE: begin
                        if (iTick) begin
                            r_angle <= w_next_angle;
`ifdef SERVO_SLEW_ACCEL_EN
                            r_step  <= (w_step >= MAX_STEP_W) ? MAX_STEP_W : (w_step + STEP_ONE);
                            r_dir   <= w_dir;
`endif
                            if (w_land) begin
                                r_state  <= ST_SETTLE;
                                r_dwell  <= '0;
                                r_moving <= 1'b0;
`ifdef SERVO_SLEW_ACCEL_EN
                                r_step   <= STEP_W;
`endif
                            end
                        end else if (w_tgt == r_angle) begin
                            r_state  <= ST_SETTLE;
                            r_dwell  <= '0;
                            r_moving <= 1'b0;
`ifdef SERVO_SLEW_ACCEL_EN
                            r_step   <= STEP_W;
`endif
                        end
                    end
                    ST_SETTLE: begin
                        if (w_tgt != r_angle) begin
                            r_state  <= ST_MOVE;
                            r_dwell  <= '0;
                            r_moving <= 1'b1;
                        end else if (iTick) begin
                            if (r_dwell == DWELL_LAST) begin
                                r_state <= ST_IDLE;
                                r_dwell <= '0;
                                r_done  <= 1'b1;
                            end else begin
                                r_dwell <= r_dwell + DWELL_ONE;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign oAngle  = r_angle;
    assign oMoving = r_moving;
    assign oDone   = r_done;

endmodule

// File: rtl/servo_slew_ctrl.sv
// Multi-channel servo slew-rate limiter: shared rate tick plus NUM_CH independent channels.
// Optional SERVO_SLEW_ACCEL_EN enables the accelerating step ramp in every channel.
module servo_slew_ctrl
    import servo_slew_pkg::*;
#(
    parameter int NUM_CH       = 6,
    parameter int ANGLE_W      = 8,
    parameter int MIN_ANGLE    = 0,
    parameter int MAX_ANGLE    = 180,
    parameter int RESET_ANGLE  = 90,
    parameter int STEP         = 1,
`ifdef SERVO_SLEW_ACCEL_EN
    parameter int MAX_STEP     = 4,
`endif
    parameter int TICK_W       = 22,
    parameter int SETTLE_TICKS = 8
) (
    input  logic                        iClk,
    input  logic                        iRst,
    input  logic [1:0]                  iSpeed,
    input  logic [NUM_CH-1:0]           iEn,
    input  logic [NUM_CH*ANGLE_W-1:0]   iTarget,
    output logic [NUM_CH*ANGLE_W-1:0]   oAngle,
    output logic [NUM_CH-1:0]           oMoving,
    output logic [NUM_CH-1:0]           oDone,
    output logic                        oTick
);

    localparam logic [TICK_W:0] ACC_ONE = (TICK_W+1)'(1);

    logic [TICK_W-1:0] r_acc;
    logic              r_tick;
    logic [TICK_W:0]   w_acc_sum;

    // The carry out of the accumulator is the rate tick; faster speeds wrap sooner.
    assign w_acc_sum = {1'b0, r_acc} + (TICK_W+1)'(iSpeed) + ACC_ONE;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_acc  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_acc  <= w_acc_sum[TICK_W-1:0];
            r_tick <= w_acc_sum[TICK_W];
        end
    end

    assign oTick = r_tick;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        servo_slew_channel #(
            .ANGLE_W      (ANGLE_W),
            .MIN_ANGLE    (MIN_ANGLE),
            .MAX_ANGLE    (MAX_ANGLE),
            .RESET_ANGLE  (RESET_ANGLE),
            .STEP         (STEP),
`ifdef SERVO_SLEW_ACCEL_EN
            .MAX_STEP     (MAX_STEP),
`endif
            .SETTLE_TICKS (SETTLE_TICKS)
        ) u_ch (
            .iClk    (iClk),
            .iRst    (iRst),
            .iTick   (r_tick),
            .iEn     (iEn[g]),
            .iTarget (iTarget[g*ANGLE_W +: ANGLE_W]),
            .oAngle  (oAngle[g*ANGLE_W +: ANGLE_W]),
            .oMoving (oMoving[g]),
            .oDone   (oDone[g])
        );
    end

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Directed self-checking bench for servo_slew_ctrl (4-bit tick accumulator, 8-tick dwell).
// Exercises the SERVO_SLEW_ACCEL_EN ramp when that macro is defined.
module tb_servo_slew_ctrl;

    localparam int NUM_CH  = 6;
    localparam int ANGLE_W = 8;

    logic                      iClk = 1'b0;
    logic                      iRst;
    logic [1:0]                iSpeed;
    logic [NUM_CH-1:0]         iEn;
    logic [NUM_CH*ANGLE_W-1:0] iTarget;
    logic [NUM_CH*ANGLE_W-1:0] oAngle;
    logic [NUM_CH-1:0]         oMoving;
    logic [NUM_CH-1:0]         oDone;
    logic                      oTick;

    int n_checks = 0;
    int n_pass   = 0;
    int last_period;
    int dev;

`ifdef SERVO_SLEW_ACCEL_EN
    int accel_exp [7] = '{91, 93, 96, 100, 104, 108, 110};
`endif

    always #5 iClk = ~iClk;

    servo_slew_ctrl #(
        .NUM_CH       (NUM_CH),
        .ANGLE_W      (ANGLE_W),
        .MIN_ANGLE    (0),
        .MAX_ANGLE    (180),
        .RESET_ANGLE  (90),
        .STEP         (1),
`ifdef SERVO_SLEW_ACCEL_EN
        .MAX_STEP     (4),
`endif
        .TICK_W       (4),
        .SETTLE_TICKS (8)
    ) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iSpeed  (iSpeed),
        .iEn     (iEn),
        .iTarget (iTarget),
        .oAngle  (oAngle),
        .oMoving (oMoving),
        .oDone   (oDone),
        .oTick   (oTick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic [31:0] ang(input int ch);
        return 32'(oAngle[ch*ANGLE_W +: ANGLE_W]);
    endfunction

    task automatic set_tgt(input int ch, input int v);
        iTarget[ch*ANGLE_W +: ANGLE_W] = ANGLE_W'(v);
    endtask

    // Wait (bounded) until a tick is visible, then one more edge so the channels consume it.
    task automatic next_step();
        int n = 0;
        while (oTick !== 1'b1 && n < 64) begin
            @(negedge iClk);
            n++;
        end
        assert (n < 64) else begin
            n_checks++;
            $error("FAIL tick_wait: observed no tick after %0d cycles, expected one", n);
        end
        @(negedge iClk);
        last_period = n + 1;
    endtask

    initial begin
        // Reset state
        iRst    = 1'b1;
        iSpeed  = 2'd0;
        iEn     = '1;
        iTarget = {NUM_CH{8'd90}};
        repeat (3) @(negedge iClk);
        for (int c = 0; c < NUM_CH; c++) check($sformatf("rst_ang%0d", c), ang(c), 90);
        check("rst_done", 32'(oDone), 0);
        check("rst_moving", 32'(oMoving), 0);
        check("rst_tick", 32'(oTick), 0);
        iRst = 1'b0;
        @(negedge iClk);
        check("rel_done", 32'(oDone), 32'h3F);
        check("rel_moving", 32'(oMoving), 0);

        // Slow slew on ch0: one step per 16 cycles, then an 8-tick dwell
        set_tgt(0, 95);
        @(negedge iClk);
        check("s_mov_start", 32'(oMoving), 32'h01);
        check("s_done_drop", 32'(oDone), 32'h3E);
        for (int i = 0; i < 5; i++) begin
            next_step();
            check($sformatf("s_ang%0d", i), ang(0), 91 + i);
            check($sformatf("s_mov%0d", i), 32'(oMoving[0]), 32'(i < 4));
        end
        check("s_period", last_period, 16);
        repeat (7) next_step();
        check("s_dwell7_done", 32'(oDone[0]), 0);
        check("s_dwell7_mov", 32'(oMoving[0]), 0);
        next_step();
        check("s_done", 32'(oDone[0]), 1);
        check("s_final_ang", ang(0), 95);

        // Faster rate: tick every 4 cycles
        iSpeed = 2'd3;
        next_step();
        next_step();
        check("rate_period", last_period, 4);

        // Clamp and reversal on ch1
        set_tgt(1, 250);
        @(negedge iClk);
        repeat (10) next_step();
        check("c_ang100", ang(1), 100);
        set_tgt(1, 50);
        next_step();
        check("c_rev99", ang(1), 99);
        dev = 0;
        for (int i = 0; i < 49; i++) begin
            next_step();
            if (ang(1) != 32'(98 - i)) dev++;
        end
        check("c_down_dev", dev, 0);
        check("c_floor50", ang(1), 50);
        set_tgt(1, 250);
        @(negedge iClk);
        dev = 0;
        for (int i = 0; i < 133; i++) begin
            next_step();
            if (ang(1) != 32'((51 + i > 180) ? 180 : 51 + i)) dev++;
        end
        check("c_up_dev", dev, 0);
        check("c_ceil180", ang(1), 180);
        check("c_ceil_mov", 32'(oMoving[1]), 0);

        // Enable hold on ch2 during move and during dwell
        set_tgt(2, 100);
        @(negedge iClk);
        repeat (3) next_step();
        check("h_ang93", ang(2), 93);
        iEn[2] = 1'b0;
        repeat (5) next_step();
        check("h_frozen", ang(2), 93);
        check("h_frozen_mov", 32'(oMoving[2]), 1);
        iEn[2] = 1'b1;
        next_step();
        check("h_resume", ang(2), 94);
        repeat (6) next_step();
        check("h_arrive", ang(2), 100);
        repeat (3) next_step();
        iEn[2] = 1'b0;
        repeat (10) next_step();
        check("h_dwell_frozen", 32'(oDone[2]), 0);
        iEn[2] = 1'b1;
        repeat (4) next_step();
        check("h_dwell7", 32'(oDone[2]), 0);
        next_step();
        check("h_done", 32'(oDone[2]), 1);

        // Settle abort on ch3 at dwell 3
        set_tgt(3, 92);
        @(negedge iClk);
        repeat (2) next_step();
        check("a_ang92", ang(3), 92);
        repeat (3) next_step();
        set_tgt(3, 93);
        @(negedge iClk);
        check("a_mov", 32'(oMoving[3]), 1);
        check("a_done", 32'(oDone[3]), 0);
        next_step();
        check("a_ang93", ang(3), 93);
        repeat (7) next_step();
        check("a_dwell7", 32'(oDone[3]), 0);
        next_step();
        check("a_done_final", 32'(oDone[3]), 1);

`ifdef SERVO_SLEW_ACCEL_EN
        // Accelerating ramp on ch4, reversal on ch5
        set_tgt(4, 110);
        @(negedge iClk);
        for (int i = 0; i < 7; i++) begin
            next_step();
            check($sformatf("x_ang%0d", i), ang(4), 32'(accel_exp[i]));
        end
        set_tgt(5, 110);
        @(negedge iClk);
        repeat (3) next_step();
        check("x_rev_pre", ang(5), 96);
        set_tgt(5, 80);
        next_step();
        check("x_rev1", ang(5), 95);
        next_step();
        check("x_rev2", ang(5), 93);
        next_step();
        check("x_rev3", ang(5), 90);
`else
        // Constant step on ch4, reversal mid-move
        set_tgt(4, 110);
        @(negedge iClk);
        repeat (3) next_step();
        check("k_ang93", ang(4), 93);
        set_tgt(4, 80);
        next_step();
        check("k_rev92", ang(4), 92);
`endif

        // Synchronous reset while a channel is moving
        check("r_premove", 32'(oMoving != '0), 1);
        iRst    = 1'b1;
        iTarget = {NUM_CH{8'd90}};
        @(negedge iClk);
        for (int c = 0; c < NUM_CH; c++) check($sformatf("r_ang%0d", c), ang(c), 90);
        check("r_moving", 32'(oMoving), 0);
        check("r_done", 32'(oDone), 0);
        check("r_tick", 32'(oTick), 0);
        iRst = 1'b0;
        @(negedge iClk);
        check("r_rel_done", 32'(oDone), 32'h3F);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
